// File: rtl/subgen_serial.sv
// subgen_serial: bit-serial subtractor, r = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell walks the latched operands. A start/done handshake
// brackets each operation.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  launch request, honoured only in IDLE or DONE
//   a, b   minuend / subtrahend (NBITS), latched on an accepted start
//   bin    borrow-in, latched on an accepted start
//   r      difference, valid from done until the next accepted start
//   bout   borrow-out, 1 iff unsigned a < b + bin
//   ovf    two's-complement overflow of the signed subtraction
//   busy   high while bits are being processed
//   done   one-cycle pulse when r/bout/ovf become valid
module subgen_serial #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             bin,
    output logic [NBITS-1:0] r,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [NBITS-1:0] a_sr, b_sr;
    // Holds the NBITS-1 difference bits produced so far. The final bit goes straight into r.
    logic [NBITS-2:0] d_sr;
    logic [NBITS-1:0] d_next;
    logic             w;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;

    logic x, y, d, w_nxt;
    logic accept, last_bit;

    always_comb begin
        x        = a_sr[0];
        y        = b_sr[0];
        d        = x ^ y ^ w;
        w_nxt    = (~x & y) | (~(x ^ y) & w);
        d_next   = {d, d_sr};
        accept   = start && ((state == IDLE) || (state == DONE));
        last_bit = (state == SHIFT) && (cnt == LAST);
        busy     = (state == SHIFT);
        done     = (state == DONE);

        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            w     <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            r     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            w     <= bin;
            cnt   <= '0;
            a_msb <= a[NBITS-1];
            b_msb <= b[NBITS-1];
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            d_sr <= d_next[NBITS-1:1];
            w    <= w_nxt;
            // The state change happens at NBITS-1, so the counter is parked instead of wrapping.
            cnt  <= last_bit ? '0 : cnt + CW'(1);
            if (last_bit) begin
                r    <= d_next;
                bout <= w_nxt;
                ovf  <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_subgen_serial.sv
// tb_subgen_serial: scoreboard bench for subgen_serial at NBITS=16 and NBITS=4.
// Stimulus threads push expected results (value and done cycle) into queues.
// Monitors pop and compare whenever done is high.
module tb_subgen_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [15:0] r;
        logic        bout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    // Reference: plain integer arithmetic for {bout, r} = a - b - bin. ovf follows the operand/result sign rule.
    function automatic exp_t ref_model(input int n, input int unsigned av, input int unsigned bv,
                                       input int bi, input int c);
        exp_t e;
        int          diff;
        int unsigned mask, rr, am, bm, rm;
        mask   = (32'd1 << n) - 32'd1;
        diff   = int'(av) - int'(bv) - bi;
        rr     = int'(diff) & mask;
        am     = (av >> (n - 1)) & 1;
        bm     = (bv >> (n - 1)) & 1;
        rm     = (rr >> (n - 1)) & 1;
        e.r    = 16'(rr);
        e.bout = (diff < 0);
        e.ovf  = (am != bm) && (rm != am);
        e.cyc  = c;
        return e;
    endfunction

    // NBITS = 16 instance
    logic        rst16, st16, bin16, bout16, ovf16, busy16, done16;
    logic [15:0] a16, b16, r16;

    subgen_serial #(.NBITS(16)) dut16 (
        .clk(clk), .rst(rst16), .start(st16), .a(a16), .b(b16), .bin(bin16),
        .r(r16), .bout(bout16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    // NBITS = 4 instance
    logic       rst4, st4, bin4, bout4, ovf4, busy4, done4;
    logic [3:0] a4, b4, r4;

    subgen_serial #(.NBITS(4)) dut4 (
        .clk(clk), .rst(rst4), .start(st4), .a(a4), .b(b4), .bin(bin4),
        .r(r4), .bout(bout4), .ovf(ovf4), .busy(busy4), .done(done4)
    );

    // Called at posedge+1. start is accepted at the next edge. done is expected NBITS edges after that.
    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic bi, input bit push);
        a16 = av; b16 = bv; bin16 = bi; st16 = 1'b1;
        if (push) q16.push_back(ref_model(16, av, bv, bi, cyc + 1 + 16));
        @(posedge clk); #1;
        st16 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        a4 = av; b4 = bv; bin4 = bi; st4 = 1'b1;
        q4.push_back(ref_model(4, av, bv, bi, cyc + 1 + 4));
        @(posedge clk); #1;
        st4 = 1'b0;
    endtask

    // Monitors
    int run16 = 0;
    int run4  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst16) run16 = 0;
        else if (busy16) run16++;
        else if (run16 != 0) begin
            chk("busy_len16", run16, 16);
            run16 = 0;
        end
        if (done16) begin
            chk("busy_done_excl16", busy16, 0);
            if (q16.size() == 0) chk("unexpected_done16", 1, 0);
            else begin
                e = q16.pop_front();
                chk("r16", r16, e.r);
                chk("bout16", bout16, e.bout);
                chk("ovf16", ovf16, e.ovf);
                chk("done_cycle16", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst4) run4 = 0;
        else if (busy4) run4++;
        else if (run4 != 0) begin
            chk("busy_len4", run4, 4);
            run4 = 0;
        end
        if (done4) begin
            chk("busy_done_excl4", busy4, 0);
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                e = q4.pop_front();
                chk("r4", r4, 32'(e.r[3:0]));
                chk("bout4", bout4, e.bout);
                chk("ovf4", ovf4, e.ovf);
                chk("done_cycle4", cyc, e.cyc);
            end
        end
    end

    task automatic thread16();
        logic [15:0] da [5];
        logic [15:0] db [5];
        logic        dc [5];
        da = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
        db = '{16'h0234, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF};
        dc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst16 = 1'b1; st16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r16", r16, 0);
        chk("rst_flags16", {bout16, ovf16, busy16, done16}, 0);
        rst16 = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            issue16(da[i], db[i], dc[i], 1'b1);
            repeat (18) @(posedge clk);
            #1;
        end

        // start during SHIFT is ignored, and operand changes after acceptance have no effect
        issue16(16'h00F0, 16'h0030, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        st16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h1234; bin16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            @(posedge clk); #1;
        end
        repeat (12) @(posedge clk);
        #1;

        // back-to-back: start presented during DONE
        issue16(16'h0100, 16'h0001, 1'b0, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        issue16(16'h0010, 16'h0001, 1'b0, 1'b1);
        repeat (18) @(posedge clk);
        #1;

        // reset while bit 7 is being processed aborts the operation
        issue16(16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        chk("midrst_r16", r16, 0);
        chk("midrst_flags16", {bout16, ovf16, busy16, done16}, 0);
        issue16(16'h0003, 16'h0002, 1'b0, 1'b1);
        repeat (18) @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat (16) @(posedge clk);
            else repeat (17 + $urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic thread4();
        rst4 = 1'b1; st4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r4", r4, 0);
        chk("rst_flags4", {bout4, ovf4, busy4, done4}, 0);
        rst4 = 1'b0;
        @(posedge clk); #1;

        issue4(4'h3, 4'h5, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            issue4(4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat (4) @(posedge clk);
            else repeat (5 + $urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            thread16();
            thread4();
        join
        chk("pending16", q16.size(), 0);
        chk("pending4", q4.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", passed, total);
        $fatal(1, "timeout");
    end

endmodule
